bg_rom_arbiter: RTL
===================

# bg_rom_arbiter

Shares the single-port, 1-cycle-latency background ROM between the VGA pixel fetch path and a game-logic query port, for example collision or terrain lookups. The pixel path owns the ROM during active display. Queries are granted only during blanking through a req/ack handshake. The block sits between the VGA controller timing signals (`DrawX`, `DrawY`, `blank`) and the palette lookup, and emits an aligned palette index stream.

## Interface
- `ADDR_W`, 17: ROM address width.
- `DATA_W`, 4: ROM word / palette index width.
- `STARVE_LIMIT`, 1024: wait cycles before `q_starve` sets.
- `vga_clk` in 1: pixel clock. The only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `DrawX`, `DrawY` in 10 each: current pixel coordinates.
- `blank` in 1: 1 = active display, 0 = blanking.
- `rom_address` out ADDR_W: ROM address. Combinational mux output.
- `rom_q` in DATA_W: ROM data, valid 1 cycle after its address.
- `pix_index` out DATA_W: palette index for the pixel presented 2 cycles earlier.
- `pix_blank` out 1: `blank` delayed 2 cycles, aligned with `pix_index`.
- `q_req` in 1: query request, level. Hold until `q_ack`.
- `q_addr` in ADDR_W: query address. Stable while `q_req`=1.
- `q_ack` out 1: one-cycle pulse. `q_data` is valid in the same cycle.
- `q_data` out DATA_W: query result. Held until the next ack.
- `q_starve` out 1: sticky flag, set when one request waits `STARVE_LIMIT` cycles.

## Operation
- Pixel address is `(DrawX*256/640) + (DrawY*256/480)*256`, using truncating integer division. Compute intermediates at ADDR_W or wider.
- `rom_address` is the query address only when state=IDLE, `q_req`=1 and `blank`=0. Otherwise it is the pixel address.
- FSM states:
  - IDLE:
    - On grant, go to READ.
    - Otherwise stay in IDLE, and if `q_req`=1, increment `wait_cnt` (saturating).
  - READ: register `rom_q` into `q_data`, then go to ACK.
  - ACK: `q_ack`=1 for exactly this cycle. Go to IDLE. No grant is possible in ACK.
- Grant condition:
  - It is evaluated the cycle it occurs, with no lookahead.
  - If `blank` rises during READ, the pixel path takes the port. The query read already launched and is unaffected.
- `wait_cnt` handling:
  - It clears on grant.
  - When it reaches `STARVE_LIMIT`, `q_starve` sets and stays set until reset.
- Pixel pipeline:
  - Stage 1 delays `blank` by one cycle.
  - Stage 2 registers `rom_q` into `pix_index` and delays `blank` again into `pix_blank`.
  - `pix_index` is forced to 0 when the stage-1 `blank` is 0.
- Requester protocol:
  - Deasserting `q_req` before ack is illegal. The bench flags it as an assertion.
  - A new request may be asserted in the cycle after ack.
- Reset (also when asserted mid-operation):
  - FSM goes to IDLE, `wait_cnt`=0.
  - All outputs go to 0: `pix_index`, `pix_blank`, `q_ack`, `q_data`, `q_starve`.
  - `rom_address` then follows its combinational rule.

## Timing
- Pixel path latency is 2 cycles: coordinates at cycle t give `pix_index` and `pix_blank` at t+2.
- Query, best case:
  - `q_req` seen with `blank`=0 at cycle t is granted at t.
  - `q_ack` and `q_data` are valid at t+2.
  - Maximum throughput is 1 query per 3 cycles while blanking.
- Worst-case wait is one full active line plus a retrace edge. At 640 active pixels this is well under `STARVE_LIMIT`.
- If `q_req` and `blank` fall in the same cycle, the query is granted that cycle.

## Structure
- Package `bg_rom_pkg` holds:
  - `ADDR_W`, `DATA_W`.
  - Source/screen size constants: 256, 256, 640, 480.
  - The FSM state enum `{IDLE, READ, ACK}`.
- Sub-module `bg_pixel_addr_gen` holds only the combinational coordinate-to-address scaling. The future sprite mapper reuses it.

## Test plan
- Active video, `DrawX`=320, `DrawY`=240, `blank`=1 → `rom_address`=32896 the same cycle. `pix_index` = ROM model value at t+2, with `pix_blank`=1.
- Corner pixel `DrawX`=639, `DrawY`=479 → `rom_address`=65535. `DrawX`=0, `DrawY`=0 → 0.
- During blanking, `q_req`=1, `q_addr`=0x1234; ROM model returns addr[3:0] → `q_ack` pulses 2 cycles later with `q_data`=4. `pix_index`=0 throughout.
- `q_req` raised with `blank`=1 for 200 cycles, then `blank`=0 → no grant while `blank`=1. Grant occurs on the first cycle with `blank`=0. `q_starve` stays 0.
- `blank` held at 1 for 1100 cycles with `q_req`=1 → `q_starve` rises after 1024 waiting cycles and stays high after the later ack.
- `reset_n` asserted during READ → next cycle shows state IDLE, `q_ack`=0, `q_data`=0, `pix_index`=0. After release, the re-presented request completes normally.

Source files
------------

// File: rtl/bg_rom_pkg.sv
// Shared constants and types for the background ROM arbiter and address generator.
// No logic; types and sizes only.
// Not applicable: holds no flow-controlled interfaces.
package bg_rom_pkg;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 4;

    // Background source image size and visible screen size
    localparam int SRC_W = 256;
    localparam int SRC_H = 256;
    localparam int SCR_W = 640;
    localparam int SCR_H = 480;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        ACK
    } arb_state_t;

endpackage

// File: rtl/bg_pixel_addr_gen.sv
// Scales screen coordinates onto the 256x256 background image and forms the ROM address.
// Latency: purely combinational, zero cycles.
// No backpressure; output follows the inputs continuously.
module bg_pixel_addr_gen #(
    parameter int ADDR_W = bg_rom_pkg::ADDR_W
) (
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    output logic [ADDR_W-1:0] pix_addr
);
    import bg_rom_pkg::*;

    // Intermediate width covers 1023*256 even if ADDR_W is configured narrower
    localparam int CW = (ADDR_W > 20) ? ADDR_W : 20;

    logic [CW-1:0] x_scaled;
    logic [CW-1:0] y_scaled;

    // Truncating scale of each axis, then row-major address (row stride = source width)
    always_comb begin
        x_scaled = (CW'(draw_x) * CW'(SRC_W)) / CW'(SCR_W);
        y_scaled = (CW'(draw_y) * CW'(SRC_H)) / CW'(SCR_H);
        pix_addr = ADDR_W'(x_scaled + y_scaled * CW'(SRC_W));
    end

endmodule

// File: rtl/bg_rom_arbiter.sv
// Shares the background ROM between the pixel fetch path and a blanking-only query port.
// Latency: pixel index 2 cycles after coordinates; query ack 2 cycles after grant.
// Queries are held off (req stays high) while blank=1; pixel path is never stalled.
module bg_rom_arbiter #(
    parameter int ADDR_W       = bg_rom_pkg::ADDR_W,
    parameter int DATA_W       = bg_rom_pkg::DATA_W,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] pix_index,
    output logic              pix_blank,
    input  logic              q_req,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_ack,
    output logic [DATA_W-1:0] q_data,
    output logic              q_starve
);
    import bg_rom_pkg::*;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_nxt;
    logic              grant;
    logic              blank_d1;
    logic [ADDR_W-1:0] pix_addr;

    bg_pixel_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .draw_x   (DrawX),
        .draw_y   (DrawY),
        .pix_addr (pix_addr)
    );

    // Grant is decided in the same cycle the address goes out; no lookahead
    assign grant       = (state == IDLE) && q_req && !blank;
    assign rom_address = grant ? q_addr : pix_addr;
    assign q_ack       = (state == ACK);

    // Next-state and wait counter; ACK always returns to IDLE so back-to-back grants are spaced by 3
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt    = READ;
                    wait_cnt_nxt = '0;
                end else if (q_req && (wait_cnt != CNT_W'(STARVE_LIMIT))) begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            READ:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state and wait counter registers
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Query result capture (ROM data arrives the cycle after grant) and sticky starvation flag
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            q_data   <= '0;
            q_starve <= 1'b0;
        end else begin
            if (state == READ) begin
                q_data <= rom_q;
            end
            if (wait_cnt_nxt == CNT_W'(STARVE_LIMIT)) begin
                q_starve <= 1'b1;
            end
        end
    end

    // Two-stage pixel pipeline; index is zeroed for blanking pixels since ROM may hold query data then
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_d1  <= 1'b0;
            pix_blank <= 1'b0;
            pix_index <= '0;
        end else begin
            blank_d1  <= blank;
            pix_blank <= blank_d1;
            pix_index <= blank_d1 ? rom_q : '0;
        end
    end

endmodule
